// File: rtl/spi_mem_loader.sv
// SPI slave that streams an image into an SRAM write port, all on i_clk.
// SPI pins are synchronised, edge-detected and shifted into words that are strobed to the SRAM.
module spi_mem_loader #(
    parameter int AW       = 0,
    parameter int DW       = 8,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0,
    parameter int ADDR_HDR = 0,
    // AW is clamped to 1 so the unconfigured default still elaborates
    localparam int AWP     = (AW > 0) ? AW : 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_sclk,
    input  logic           i_cs_n,
    input  logic           i_mosi,
    output logic [AWP-1:0] o_sram_waddr,
    output logic [DW-1:0]  o_sram_wdata,
    output logic           o_sram_wen,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic [AWP:0]   o_wcount
);

    localparam int HB    = (AWP + 7) / 8;
    localparam int HBITS = 8 * HB;
    localparam int MAXB  = (DW > HBITS) ? DW : HBITS;
    localparam int CNTW  = $clog2(MAXB);
    localparam logic [CNTW-1:0] HDR_LAST   = CNTW'(HBITS - 1);
    localparam logic [CNTW-1:0] WORD_LAST  = CNTW'(DW - 1);
    localparam logic [AWP:0]    WCOUNT_MAX = {1'b1, {AWP{1'b0}}};
    localparam logic            SCLK_IDLE  = 1'(CPOL);
    localparam bit              SAMPLE_RISE = (((CPOL ^ CPHA) & 1) == 0);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    logic            sample_q, sample_d;
    logic            bit_q, bit_d;
    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [DW-2:0]   word_q, word_d;
    logic [AWP-1:0]  addr_q, addr_d;
    logic [AWP:0]    wcount_q, wcount_d;
    logic [AWP-1:0]  waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wen_q, wen_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   word_full;

    assign word_full = {word_q, bit_q};

    always_comb begin
        sample_d = SAMPLE_RISE ? (sclk_s2_q & ~sclk_s3_q) : (~sclk_s2_q & sclk_s3_q);
        bit_d    = mosi_s2_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        addr_d   = addr_q;
        wcount_d = wcount_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        // Address and count advance on the cycle after each strobe
        if (wen_q) begin
            addr_d = addr_q + AWP'(1);
            if (wcount_q != WCOUNT_MAX) begin
                wcount_d = wcount_q + (AWP+1)'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (!cs_s3_q) begin
                    state_d  = (ADDR_HDR != 0) ? HDR : DATA;
                    cnt_d    = '0;
                    wcount_d = '0;
                    if (ADDR_HDR == 0) begin
                        addr_d = '0;
                    end
                end
            end
            default: begin
                if (cs_s3_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = (cnt_q != '0) || (state_q == HDR);
                    cnt_d   = '0;
                end else if (sample_q) begin
                    if (state_q == HDR) begin
                        // Header bits shift straight into the address; only the low AW bits survive
                        addr_d = (addr_q << 1) | AWP'(bit_q);
                        if (cnt_q == HDR_LAST) begin
                            state_d = DATA;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNTW'(1);
                        end
                    end else begin
                        word_d = word_full[DW-2:0];
                        if (cnt_q == WORD_LAST) begin
                            wen_d   = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = word_full;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNTW'(1);
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_s1_q <= SCLK_IDLE;
            sclk_s2_q <= SCLK_IDLE;
            sclk_s3_q <= SCLK_IDLE;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            sample_q  <= 1'b0;
            bit_q     <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            addr_q    <= '0;
            wcount_q  <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sclk_s1_q <= i_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            // cs_n gets a third stage so it lines up with the registered sample edge
            cs_s1_q   <= i_cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            mosi_s1_q <= i_mosi;
            mosi_s2_q <= mosi_s1_q;
            sample_q  <= sample_d;
            bit_q     <= bit_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            wcount_q  <= wcount_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign o_sram_waddr = waddr_q;
    assign o_sram_wdata = wdata_q;
    assign o_sram_wen   = wen_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_wcount     = wcount_q;

endmodule
